// File: rtl/simon_tone_sched.sv
// Tone scheduler for the shared speaker: arbitrates playback notes, held-button
// feedback and the lose jingle, with a silent gap after every use.
module simon_tone_sched #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned DUR_W       = 10,
    parameter int unsigned GAP_TICKS   = 50,
    parameter int unsigned ALERT_TICKS = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play_req,
    input  logic [1:0]       play_tone,
    input  logic [DUR_W-1:0] play_dur,
    input  logic             btn_req,
    input  logic [1:0]       btn_tone,
    input  logic             lose_req,
    output logic             play_ack,
    output logic             play_done,
    output logic             lose_done,
    output logic [2:0]       tone,
    output logic             speaker_en,
    output logic [1:0]       owner,
    output logic             busy
);

    localparam int unsigned DUR_MAX = (1 << DUR_W) - 1;
    localparam int unsigned CNT_MAX0 = (DUR_MAX > ALERT_TICKS) ? DUR_MAX : ALERT_TICKS;
    localparam int unsigned CNT_MAX = (CNT_MAX0 > GAP_TICKS) ? CNT_MAX0 : GAP_TICKS;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_HOLD = 3'd2,
        S_LOSE = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]       step_q, step_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [1:0]       note_q, note_d;
    logic             lose_pend_q, lose_pend_d;
    logic             play_ack_q, play_ack_d;
    logic             play_done_q, play_done_d;
    logic             lose_done_q, lose_done_d;
    logic [2:0]       tone_q, tone_d;
    logic             speaker_en_q, speaker_en_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;

    logic tick_c;
    logic lose_go_c;
    logic dur_last_c;
    logic alert_last_c;
    logic gap_last_c;
    logic step_adv_c;
    logic chg_c;

    assign tick_c       = (presc_q == PRE_W'(TICK_DIV - 1));
    assign lose_go_c    = (lose_req | lose_pend_q) && (state_q != S_LOSE);
    assign dur_last_c   = (tcnt_q == CNT_W'(dur_q - DUR_W'(1)));
    assign alert_last_c = (tcnt_q == CNT_W'(ALERT_TICKS - 1));
    assign gap_last_c   = (tcnt_q == CNT_W'(GAP_TICKS - 1));

    // Next-state, captured request data and jingle step.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dur_d      = dur_q;
        note_d     = note_q;
        step_adv_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lose_go_c) begin
                    state_d = S_LOSE;
                end else if (btn_req) begin
                    state_d = S_HOLD;
                    note_d  = btn_tone;
                end else if (play_req) begin
                    state_d = S_PLAY;
                    note_d  = play_tone;
                    dur_d   = (play_dur == '0) ? DUR_W'(1) : play_dur;
                end
            end
            S_PLAY: begin
                if (lose_go_c) begin
                    state_d = S_LOSE;
                end else if (tick_c && dur_last_c) begin
                    state_d = S_GAP;
                end
            end
            S_HOLD: begin
                if (lose_go_c) begin
                    state_d = S_LOSE;
                end else if (!btn_req) begin
                    state_d = S_GAP;
                end
            end
            S_LOSE: begin
                if (tick_c && alert_last_c) begin
                    if (step_q == 2'd3) begin
                        state_d = S_GAP;
                    end else begin
                        step_d     = step_q + 2'd1;
                        step_adv_c = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (lose_go_c) begin
                    state_d = S_LOSE;
                end else if (tick_c && gap_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_LOSE && state_q != S_LOSE) begin
            step_d = 2'd0;
        end
    end

    assign chg_c = (state_d != state_q);

    // Prescaler and tick counter restart on every state change and jingle step.
    always_comb begin
        presc_d = (chg_c || tick_c) ? '0 : presc_q + PRE_W'(1);
        tcnt_d  = tcnt_q;
        if (chg_c || step_adv_c) begin
            tcnt_d = '0;
        end else if (tick_c && (state_q == S_PLAY || state_q == S_LOSE || state_q == S_GAP)) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
        lose_pend_d = (lose_pend_q | (lose_req & (state_q != S_LOSE))) & (state_d != S_LOSE);
    end

    // Outputs derived from the upcoming state so they register alongside it.
    always_comb begin
        play_ack_d   = (state_q == S_IDLE) && (state_d == S_PLAY);
        play_done_d  = (state_q == S_PLAY) && (state_d == S_GAP);
        lose_done_d  = (state_q == S_LOSE) && (state_d == S_GAP);
        tone_d       = 3'b000;
        speaker_en_d = 1'b0;
        owner_d      = 2'd0;
        busy_d       = (state_d != S_IDLE);
        case (state_d)
            S_PLAY: begin
                tone_d       = {1'b1, note_d};
                speaker_en_d = 1'b1;
                owner_d      = 2'd1;
            end
            S_HOLD: begin
                tone_d       = {1'b1, note_d};
                speaker_en_d = 1'b1;
                owner_d      = 2'd2;
            end
            S_LOSE: begin
                tone_d       = 3'b111 - {1'b0, step_d};
                speaker_en_d = 1'b1;
                owner_d      = 2'd3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tcnt_q       <= '0;
            step_q       <= 2'd0;
            dur_q        <= '0;
            note_q       <= 2'd0;
            lose_pend_q  <= 1'b0;
            play_ack_q   <= 1'b0;
            play_done_q  <= 1'b0;
            lose_done_q  <= 1'b0;
            tone_q       <= 3'b000;
            speaker_en_q <= 1'b0;
            owner_q      <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tcnt_q       <= tcnt_d;
            step_q       <= step_d;
            dur_q        <= dur_d;
            note_q       <= note_d;
            lose_pend_q  <= lose_pend_d;
            play_ack_q   <= play_ack_d;
            play_done_q  <= play_done_d;
            lose_done_q  <= lose_done_d;
            tone_q       <= tone_d;
            speaker_en_q <= speaker_en_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
        end
    end

    assign play_ack   = play_ack_q;
    assign play_done  = play_done_q;
    assign lose_done  = lose_done_q;
    assign tone       = tone_q;
    assign speaker_en = speaker_en_q;
    assign owner      = owner_q;
    assign busy       = busy_q;

endmodule

// File: doc/simon_tone_sched.md
Name: simon_tone_sched

Overview:
- Scheduler and arbiter for the shared speaker tone generator.
- Arbitrates three sources:
  - sequence playback (timed notes);
  - player button feedback (hold-type);
  - the lose alert, which triggers a built-in 4-note jingle.
- Inserts a silent gap after every use.
- Drives the speaker block's tone/enable inputs and returns ack/done handshakes to the game FSM.

Parameters:
TICK_DIV, 50000, clock cycles per duration tick (1 ms at 50 MHz)
DUR_W, 10, width of play_dur in ticks
GAP_TICKS, 50, silent ticks after every note, hold or jingle
ALERT_TICKS, 250, ticks per jingle note

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
play_req  in  1  playback note request; held until play_ack
play_tone  in  2  playback colour
play_dur  in  DUR_W  playback note length in ticks
btn_req  in  1  player button held; level
btn_tone  in  2  colour of held button
lose_req  in  1  lose alert; single-cycle pulse
play_ack  out  1  1-cycle pulse: playback note accepted
play_done  out  1  1-cycle pulse: playback note finished
lose_done  out  1  1-cycle pulse: jingle finished
tone  out  3  to speaker tone input, {1'b1,colour} while sounding
speaker_en  out  1  speaker enable
owner  out  2  0 none, 1 play, 2 btn, 3 lose
busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0 (tone=3'b000); lose_pend=0; counters cleared.
- All outputs are registered.
- Tick: prescaler counts 0..TICK_DIV-1 and clears on every state change. Tick = prescaler at TICK_DIV-1. Tick counter increments on tick and clears on state change.
- States: IDLE, PLAY, HOLD, LOSE, GAP.
- lose_pend:
  - Set by lose_req in any state except LOSE; lose_req during LOSE is ignored.
  - Cleared on entry to LOSE.
  - lose_req itself in IDLE also counts (priority below).
- IDLE priority (evaluated each edge): lose_pend|lose_req > btn_req > play_req.
- IDLE->PLAY (edge where play_req=1 wins):
  - Capture play_tone and play_dur; dur 0 is treated as 1.
  - play_ack=1 for that one cycle.
  - tone={1,play_tone}, speaker_en=1, owner=1.
  - speaker_en stays high exactly dur*TICK_DIV cycles.
  - Then ->GAP, with play_done=1 in the first GAP cycle.
- IDLE->HOLD (btn_req=1 wins):
  - Capture btn_tone; later changes ignored.
  - tone={1,btn_tone}, speaker_en=1, owner=2.
  - Stays while btn_req=1; on btn_req=0 ->GAP next edge.
  - No ack.
- ->LOSE (from IDLE, PLAY, HOLD or GAP on the edge after lose_req; preempts everything):
  - An in-progress PLAY note is aborted; play_done is NOT pulsed.
  - A pending play_req is not acked.
  - owner=3.
  - Steps 0..3 play tones 3'b111, 3'b110, 3'b101, 3'b100, each ALERT_TICKS*TICK_DIV cycles, speaker_en continuous (no inter-note gaps).
  - After step 3 ->GAP, with lose_done=1 in the first GAP cycle.
- GAP:
  - speaker_en=0, tone=3'b000, owner=0.
  - Lasts GAP_TICKS*TICK_DIV cycles, then ->IDLE.
  - play_req and btn_req wait; lose_pend preempts GAP.
- play_req dropped before ack: no note, no handshake.
- play_req held through the done pulse is accepted again after GAP (new note). The requester must drop play_req within 1 cycle of play_ack to avoid a repeat.
- Simultaneous play_req and btn_req in IDLE: HOLD first; play is acked on the first IDLE cycle after the gap.
- reset asserted mid-note: outputs go to 0 immediately (async), no handshake pulses.
- Counter widths: tick counter sized for max(2^DUR_W-1, ALERT_TICKS, GAP_TICKS); prescaler ceil(log2(TICK_DIV)). No wrap is possible within a state.

Test Plan:
(Bench parameters: TICK_DIV=4, GAP_TICKS=2, ALERT_TICKS=3, DUR_W=4.)
1. IDLE, play_req=1, tone=2, dur=3 -> play_ack on the first cycle; tone=3'b110 and speaker_en=1 for 12 cycles; play_done 1 cycle; 8 silent cycles busy=1; then busy=0.
2. btn_req=1, btn_tone=1 for 20 cycles -> speaker_en=1, tone=3'b101, owner=2 from the next edge until the edge after release; 8-cycle gap; no acks.
3. play_req (tone 0, dur 2) and btn_req together, btn held 10 cycles -> HOLD first; play_ack in the first IDLE cycle after the 8-cycle gap; then 8 cycles of tone 3'b100.
4. lose_req pulse 5 cycles into a dur=3 play note -> LOSE next edge; no play_done; tones 111, 110, 101, 100 for 12 cycles each; lose_done; 8-cycle gap; IDLE.
5. play_dur=0 -> treated as 1: speaker_en high 4 cycles, then play_done.
6. reset low mid-jingle -> speaker_en, tone, owner and busy all 0 before the next clk edge. After release with no requests: stays IDLE with no pulses; lose_pend is 0.
